// File: rtl/fast_overlay_pkg.sv
// Shared types and constants for the FAST corner overlay path.
// Holds the FSM state enum, ring offset tables and default colours.
// No logic; imported by draw_corner_ring and ring_point_gen.
package fast_overlay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DRAW  = 2'd2
  } state_e;

  // Point index: 0 is the centre, 1..16 the ring (needs 5 bits for 16).
  localparam int IDX_W = 5;

  localparam logic [23:0] DEF_CENTER_COLOR = 24'hFFFF00;
  localparam logic [23:0] DEF_RING_COLOR   = 24'hFF2090;

  // 12-point ring of radius 2, clockwise starting at the top.
  localparam logic signed [3:0] RING12_DX [0:11] = '{
    4'sd0,  4'sd1,  4'sd2,  4'sd2,  4'sd2,  4'sd1,
    4'sd0, -4'sd1, -4'sd2, -4'sd2, -4'sd2, -4'sd1};
  localparam logic signed [3:0] RING12_DY [0:11] = '{
    4'sd2,  4'sd2,  4'sd1,  4'sd0, -4'sd1, -4'sd2,
   -4'sd2, -4'sd2, -4'sd1,  4'sd0,  4'sd1,  4'sd2};

  // 16-point ring of radius 3, clockwise starting at the top.
  localparam logic signed [3:0] RING16_DX [0:15] = '{
    4'sd0,  4'sd1,  4'sd2,  4'sd3,  4'sd3,  4'sd3,  4'sd2,  4'sd1,
    4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd3, -4'sd3, -4'sd2, -4'sd1};
  localparam logic signed [3:0] RING16_DY [0:15] = '{
    4'sd3,  4'sd3,  4'sd2,  4'sd1,  4'sd0, -4'sd1, -4'sd2, -4'sd3,
   -4'sd3, -4'sd3, -4'sd2, -4'sd1,  4'sd0,  4'sd1,  4'sd2,  4'sd3};

endpackage

// File: rtl/ring_point_gen.sv
// Maps a point index to a frame address around (cx,cy) and flags whether it is on-frame.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds idx/cx/cy stable while a write is stalled.
module ring_point_gen
  import fast_overlay_pkg::*;
#(
  parameter int X_MAX  = 10,
  parameter int Y_MAX  = 10,
  parameter int RADIUS = 2,
  parameter int AW     = 5
) (
  input  logic [IDX_W-1:0]     idx,
  input  logic signed [AW-1:0] cx,
  input  logic signed [AW-1:0] cy,
  output logic signed [AW-1:0] px,
  output logic signed [AW-1:0] py,
  output logic                 in_bounds,
  output logic                 is_center
);

  // One extra bit so an offset past either frame edge cannot wrap back on-frame.
  localparam int AW1 = AW + 1;

  if (RADIUS != 2 && RADIUS != 3) begin : g_bad_radius
    $error("ring_point_gen: RADIUS must be 2 or 3");
  end

  logic [IDX_W-1:0]     ring_i;
  logic signed [3:0]    dx;
  logic signed [3:0]    dy;
  logic signed [AW1-1:0] wx;
  logic signed [AW1-1:0] wy;

  // Offset lookup, widened add and clip test for the current point.
  always_comb begin
    ring_i    = idx - IDX_W'(1);
    dx        = '0;
    dy        = '0;
    is_center = (idx == '0);
    if (!is_center) begin
      if (RADIUS == 3) begin
        dx = RING16_DX[ring_i[3:0]];
        dy = RING16_DY[ring_i[3:0]];
      end else begin
        dx = RING12_DX[ring_i[3:0]];
        dy = RING12_DY[ring_i[3:0]];
      end
    end
    wx        = AW1'(cx) + AW1'(dx);
    wy        = AW1'(cy) + AW1'(dy);
    in_bounds = (wx >= 0) && (wx < AW1'(X_MAX)) && (wy >= 0) && (wy < AW1'(Y_MAX));
    px        = wx[AW-1:0];
    py        = wy[AW-1:0];
  end

endmodule

// File: rtl/draw_corner_ring.sv
// Reads the FAST corner flag for a position and, for corners, writes a centre dot plus ring.
// Latency: start->done 1 cycle for a non-corner, N+2 cycles for a corner with no stalls.
// Backpressure: on-frame points hold addr/data/wr_en until wr_ready; clipped points take one cycle.
module draw_corner_ring
  import fast_overlay_pkg::*;
#(
  parameter int          X_MAX        = 10,
  parameter int          Y_MAX        = 10,
  parameter int          RADIUS       = 2,
  parameter logic [23:0] CENTER_COLOR = DEF_CENTER_COLOR,
  parameter logic [23:0] RING_COLOR   = DEF_RING_COLOR,
  localparam int         AW           = $clog2((X_MAX > Y_MAX) ? X_MAX : Y_MAX) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [AW-1:0] curr_x,
  input  logic signed [AW-1:0] curr_y,
  output logic                 rd_fast,
  output logic signed [AW-1:0] x_addr_fast,
  output logic signed [AW-1:0] y_addr_fast,
  input  logic                 fast_flag,
  output logic                 wr_en,
  output logic signed [AW-1:0] x_addr_out,
  output logic signed [AW-1:0] y_addr_out,
  output logic [23:0]          wr_data,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 done
);

  // Index of the final ring point.
  localparam int NPTS = (RADIUS == 3) ? 16 : 12;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic signed [AW-1:0] cx_q, cx_d;
  logic signed [AW-1:0] cy_q, cy_d;

  logic signed [AW-1:0] px;
  logic signed [AW-1:0] py;
  logic                 in_bounds;
  logic                 is_center;
  logic                 advance;

  ring_point_gen #(
    .X_MAX  (X_MAX),
    .Y_MAX  (Y_MAX),
    .RADIUS (RADIUS),
    .AW     (AW)
  ) u_point_gen (
    .idx       (idx_q),
    .cx        (cx_q),
    .cy        (cy_q),
    .px        (px),
    .py        (py),
    .in_bounds (in_bounds),
    .is_center (is_center)
  );

  // State, point index and latched centre registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  // Next-state and output decode; all outputs idle at zero unless a state drives them.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    rd_fast     = 1'b0;
    x_addr_fast = '0;
    y_addr_fast = '0;
    wr_en       = 1'b0;
    x_addr_out  = '0;
    y_addr_out  = '0;
    wr_data     = '0;
    done        = 1'b0;
    advance     = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_fast     = 1'b1;
          x_addr_fast = curr_x;
          y_addr_fast = curr_y;
          cx_d        = curr_x;
          cy_d        = curr_y;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (fast_flag) begin
          idx_d   = '0;
          state_d = DRAW;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      DRAW: begin
        if (in_bounds) begin
          wr_en      = 1'b1;
          x_addr_out = px;
          y_addr_out = py;
          wr_data    = is_center ? CENTER_COLOR : RING_COLOR;
          advance    = wr_ready;
        end else begin
          advance    = 1'b1;
        end
        if (advance) begin
          if (idx_q == IDX_W'(NPTS)) begin
            done    = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_draw_corner_ring.sv
// Directed bench for draw_corner_ring: one RADIUS 2 and one RADIUS 3 instance on a 20x20 frame.
// Table of positions with hand-computed write counts, done cycles and last addresses,
// then hand sequences for the full ring list, clipping, backpressure, reset abort and busy inputs.
module tb_draw_corner_ring;

  localparam int XM = 20;
  localparam int YM = 20;
  localparam int AW = 6;
  localparam int C_CEN  = 24'hFFFF00;
  localparam int C_RING = 24'hFF2090;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 start_s    [2];
  logic signed [AW-1:0] cur_x      [2];
  logic signed [AW-1:0] cur_y      [2];
  logic                 rd_fast_s  [2];
  logic signed [AW-1:0] xf         [2];
  logic signed [AW-1:0] yf         [2];
  logic                 fast_flag_s[2];
  logic                 flag_sel   [2];
  logic                 wr_en_s    [2];
  logic signed [AW-1:0] xo         [2];
  logic signed [AW-1:0] yo         [2];
  logic [23:0]          wd_s       [2];
  logic                 wr_ready_s [2];
  logic                 busy_s     [2];
  logic                 done_s     [2];

  draw_corner_ring #(.X_MAX(XM), .Y_MAX(YM), .RADIUS(2)) dut_r2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .curr_x(cur_x[0]), .curr_y(cur_y[0]),
    .rd_fast(rd_fast_s[0]), .x_addr_fast(xf[0]), .y_addr_fast(yf[0]), .fast_flag(fast_flag_s[0]),
    .wr_en(wr_en_s[0]), .x_addr_out(xo[0]), .y_addr_out(yo[0]), .wr_data(wd_s[0]),
    .wr_ready(wr_ready_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  draw_corner_ring #(.X_MAX(XM), .Y_MAX(YM), .RADIUS(3)) dut_r3 (
    .clk(clk), .rst(rst), .start(start_s[1]), .curr_x(cur_x[1]), .curr_y(cur_y[1]),
    .rd_fast(rd_fast_s[1]), .x_addr_fast(xf[1]), .y_addr_fast(yf[1]), .fast_flag(fast_flag_s[1]),
    .wr_en(wr_en_s[1]), .x_addr_out(xo[1]), .y_addr_out(yo[1]), .wr_data(wd_s[1]),
    .wr_ready(wr_ready_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  // FAST SRAM stand-in: the flag answers one cycle after the read strobe.
  always @(posedge clk) begin
    fast_flag_s[0] <= rd_fast_s[0] & flag_sel[0];
    fast_flag_s[1] <= rd_fast_s[1] & flag_sel[1];
  end

  int n_chk = 0;
  int n_fail = 0;
  int wx[$], wy[$], wd[$], wc[$];
  int rd_cnt, rd_x, rd_y, done_cnt, done_cyc, busy_after, viol, hold_bad, post_bad;
  int hx, hy, hd;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one start on instance d and records every cycle until done (or abort/timeout).
  task automatic run(input int d, input int x, input int y, input bit flag,
                     input int stall_at, input int stall_len, input int abort_at, input int chg_at);
    int r;
    bit fin;
    wx.delete(); wy.delete(); wd.delete(); wc.delete();
    rd_cnt = 0; rd_x = -99; rd_y = -99; done_cnt = 0; done_cyc = -1; busy_after = -1;
    viol = 0; hold_bad = 0; post_bad = 0; hx = -1; hy = -1; hd = -1;
    flag_sel[d] = flag;
    cur_x[d] = AW'(x);
    cur_y[d] = AW'(y);
    r = 0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      start_s[d] = (r == 0) || (r == chg_at);
      if (chg_at >= 0 && r >= chg_at) begin
        cur_x[d] = 6'sd9;
        cur_y[d] = 6'sd9;
      end
      wr_ready_s[d] = !(r >= stall_at && r < stall_at + stall_len);
      rst = (r == abort_at);
      @(negedge clk);
      if (rd_fast_s[d]) begin
        rd_cnt++; rd_x = int'(xf[d]); rd_y = int'(yf[d]);
      end else if (xf[d] != 0 || yf[d] != 0) viol++;
      if (!wr_en_s[d] && wd_s[d] != 0) viol++;
      if (rd_fast_s[d] && (wr_en_s[d] || done_s[d])) viol++;
      if (wr_en_s[d] && wr_ready_s[d] && (abort_at < 0 || r < abort_at)) begin
        wx.push_back(int'(xo[d])); wy.push_back(int'(yo[d]));
        wd.push_back(int'(wd_s[d])); wc.push_back(r);
      end
      if (r == stall_at) begin
        hx = int'(xo[d]); hy = int'(yo[d]); hd = int'(wd_s[d]);
      end
      if (stall_len > 0 && r >= stall_at && r <= stall_at + stall_len)
        if (!wr_en_s[d] || int'(xo[d]) != hx || int'(yo[d]) != hy || int'(wd_s[d]) != hd) hold_bad++;
      if (abort_at >= 0 && r > abort_at)
        if (wr_en_s[d] || done_s[d] || busy_s[d] || rd_fast_s[d] || wd_s[d] != 0 ||
            xo[d] != 0 || yo[d] != 0) post_bad++;
      if (done_s[d]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = r;
      end
      if (done_cyc >= 0 && r == done_cyc + 1) busy_after = int'(busy_s[d]);
      fin = (done_cyc >= 0 && r >= done_cyc + 3) || (abort_at >= 0 && r >= abort_at + 4) || (r >= 60);
      r++;
    end
    @(posedge clk); #1;
    start_s[d] = 1'b0; wr_ready_s[d] = 1'b1; rst = 1'b0;
  endtask

  // Expected 17-write list for RADIUS 3 centred at (5,5).
  task automatic check_r3_list(input string tag);
    int ex[17] = '{5, 5, 6, 7, 8, 8, 8, 7, 6, 5, 4, 3, 2, 2, 2, 3, 4};
    int ey[17] = '{5, 8, 8, 7, 6, 5, 4, 3, 2, 2, 2, 3, 4, 5, 6, 7, 8};
    chk({tag, "_nwr"}, wx.size(), 17);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("%s_wr%0d_x", tag, i), (i < wx.size()) ? wx[i] : -99, ex[i]);
      chk($sformatf("%s_wr%0d_y", tag, i), (i < wy.size()) ? wy[i] : -99, ey[i]);
      chk($sformatf("%s_wr%0d_data", tag, i), (i < wd.size()) ? wd[i] : -99, (i == 0) ? C_CEN : C_RING);
    end
  endtask

  typedef struct {
    int d; int x; int y; bit flag; int nwr; int dcyc; int lx; int ly;
  } vec_t;

  vec_t vt[7];

  initial begin
    // d=0 is RADIUS 2 (N=12), d=1 is RADIUS 3 (N=16); done at N+2 for corners.
    vt[0] = '{1,  5,  5, 1'b1, 17, 18,  4,  8};
    vt[1] = '{1,  3,  4, 1'b0,  0,  1, -1, -1};
    vt[2] = '{0,  0,  0, 1'b1,  5, 14,  2,  0};
    vt[3] = '{1, 19, 19, 1'b1,  6, 18, 16, 19};
    vt[4] = '{0,  5,  5, 1'b1, 13, 14,  4,  7};
    vt[5] = '{0, 19,  0, 1'b1,  5, 14, 18,  2};
    vt[6] = '{1,  0, 19, 1'b1,  6, 18,  0, 16};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; cur_x[d] = '0; cur_y[d] = '0;
      flag_sel[d] = 1'b0; wr_ready_s[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outputs_d%0d", d),
          int'(rd_fast_s[d] | wr_en_s[d] | busy_s[d] | done_s[d] | (xf[d] != 0) | (yf[d] != 0) |
               (xo[d] != 0) | (yo[d] != 0) | (wd_s[d] != 0)), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run(vt[i].d, vt[i].x, vt[i].y, vt[i].flag, -1, 0, -1, -1);
      chk($sformatf("v%0d_rd_cnt", i), rd_cnt, 1);
      chk($sformatf("v%0d_rd_x", i), rd_x, vt[i].x);
      chk($sformatf("v%0d_rd_y", i), rd_y, vt[i].y);
      chk($sformatf("v%0d_nwr", i), wx.size(), vt[i].nwr);
      chk($sformatf("v%0d_done_cyc", i), done_cyc, vt[i].dcyc);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("v%0d_busy_after", i), busy_after, 0);
      chk($sformatf("v%0d_protocol", i), viol, 0);
      if (vt[i].nwr > 0) begin
        chk($sformatf("v%0d_last_x", i), wx[wx.size()-1], vt[i].lx);
        chk($sformatf("v%0d_last_y", i), wy[wy.size()-1], vt[i].ly);
      end
    end

    // Full RADIUS 3 ring: one write per cycle on cycles 2..18.
    run(1, 5, 5, 1'b1, -1, 0, -1, -1);
    check_r3_list("full");
    for (int i = 0; i < 17; i++)
      chk($sformatf("full_wr%0d_cyc", i), (i < wc.size()) ? wc[i] : -99, i + 2);

    // RADIUS 2 at the origin: only the centre and four ring points survive clipping.
    run(0, 0, 0, 1'b1, -1, 0, -1, -1);
    begin
      int ecx[5] = '{0, 0, 1, 2, 2};
      int ecy[5] = '{0, 2, 2, 1, 0};
      chk("clip_nwr", wx.size(), 5);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("clip_wr%0d_x", i), (i < wx.size()) ? wx[i] : -99, ecx[i]);
        chk($sformatf("clip_wr%0d_y", i), (i < wy.size()) ? wy[i] : -99, ecy[i]);
      end
      chk("clip_done_cyc", done_cyc, 14);
    end

    // Stall ring point 4, i.e. (8,5), for three cycles starting at cycle 7.
    run(1, 5, 5, 1'b1, 7, 3, -1, -1);
    chk("bp_hold_stable", hold_bad, 0);
    chk("bp_hold_x", hx, 8);
    chk("bp_hold_y", hy, 5);
    chk("bp_hold_data", hd, C_RING);
    chk("bp_done_cyc", done_cyc, 21);
    chk("bp_done_cnt", done_cnt, 1);
    check_r3_list("bp");

    // Reset during ring point 6 (cycle 9): seven writes before it, then silence.
    run(1, 5, 5, 1'b1, -1, 0, 9, -1);
    chk("abort_nwr", wx.size(), 7);
    chk("abort_outputs_zero", post_bad, 0);
    chk("abort_no_done", done_cnt, 0);
    run(1, 5, 5, 1'b1, -1, 0, -1, -1);
    chk("restart_first_x", (wx.size() > 0) ? wx[0] : -99, 5);
    chk("restart_first_y", (wy.size() > 0) ? wy[0] : -99, 5);
    chk("restart_first_data", (wd.size() > 0) ? wd[0] : -99, C_CEN);
    chk("restart_nwr", wx.size(), 17);
    chk("restart_done_cyc", done_cyc, 18);

    // start pulse and new position at cycle 5 while drawing must be ignored.
    run(1, 5, 5, 1'b1, -1, 0, -1, 5);
    check_r3_list("busy_in");
    chk("busy_in_done_cnt", done_cnt, 1);
    chk("busy_in_rd_cnt", rd_cnt, 1);
    chk("busy_in_done_cyc", done_cyc, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
